serial_cmp_ctrl: RTL and testbench
==================================

# serial_cmp_ctrl

Sequential magnitude comparator controller that time-shares one 1-bit three-outcome (lt/eq/gt) comparator slice across an N-bit operand pair. It examines bits MSB-first, one per clock, and terminates early on the first differing bit. It sits beside the 1-bit comparator datapath and gives it a start/done handshake, so wide compares cost one slice instead of WIDTH slices.

## Interface
- WIDTH, 8, operand width in bits (≥2)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request; accepted only while ready=1
- a  in  WIDTH  operand A, sampled at accepting edge
- b  in  WIDTH  operand B, sampled at accepting edge
- ready  out  1  controller idle, can accept start
- busy  out  1  compare in progress (RUN state)
- done  out  1  one-cycle pulse, result valid and newly updated
- gt  out  1  A > B, held until next accepted start
- eq  out  1  A == B, held
- lt  out  1  A < B, held

## Operation
- States: IDLE, RUN, DONE.
- IDLE: ready=1. start=1 at an edge → latch a,b into shadow registers, idx ← WIDTH-1, clear gt/eq/lt to 0, go to RUN.
- RUN: busy=1. Slice compares a_q[idx] vs b_q[idx].
  - Bits differ → set gt (a_q[idx]=1) or lt (b_q[idx]=1), go to DONE.
  - Bits equal, idx≠0 → idx ← idx-1, stay in RUN.
  - Bits equal, idx=0 → set eq, go to DONE.
- DONE: done=1 for exactly one cycle, then unconditionally to IDLE.
- Exactly one of gt/eq/lt is 1 after any completed compare; all three are 0 from reset until the first done, and from an accepting edge until its done.
- start is ignored in RUN and DONE. It is not queued. The requester re-asserts it in IDLE.
- Operand inputs are don't-care after the accepting edge. Only the shadow copies are used.
- idx is $clog2(WIDTH) bits wide and never wraps. The idx=0 equal case exits RUN before a decrement.

## Timing
- Reset, synchronous: state=IDLE, ready=1, busy=0, done=0, gt=eq=lt=0, idx=WIDTH-1, shadows=0.
- rst asserted in any state, including mid-RUN or DONE: the next edge forces reset values, and no done is produced for the aborted compare.
- ready, busy and done decode from the state register only. They are glitch-free registered-state outputs.
- Latency: start accepted at edge 0, first differing bit at position p (MSB=WIDTH-1). DONE is entered at edge WIDTH-p, so done is high in the cycle after that edge. Equal operands take WIDTH edges.
- Minimum latency is 1 compare cycle (MSB differs). Maximum is WIDTH compare cycles.
- Back-to-back: ready returns one edge after done. Throughput is one compare per (compare cycles + 2) cycles.
- gt/eq/lt update on the same edge that enters DONE, are stable while done=1, and hold through IDLE.

## Structure
- cmp_pkg holds:
  - typedef enum logic [1:0] cmp_state_t {IDLE, RUN, DONE}
  - typedef enum logic [1:0] cmp_res_t {RES_NONE, RES_LT, RES_EQ, RES_GT}. Internal result register; gt/eq/lt decode from it.
- Sub-module cmp_slice_1bit: combinational, inputs a_bit, b_bit; outputs bit_gt, bit_lt. It is instantiated once and fed by the idx mux.
- Controller holds the FSM, idx counter, shadow registers and result register.

## Test plan
- Reset then idle, WIDTH=8: rst=1 for 2 cycles → ready=1, busy=0, done=0, gt=eq=lt=0. start=0 for 5 cycles → no change.
- MSB differs: a=8'h80, b=8'h7F, start one cycle → busy for 1 cycle, done pulse, gt=1 held. Repeat with a=8'h7F, b=8'h80 → lt=1 after 1 compare cycle.
- LSB differs: a=8'h54, b=8'h55 → 8 compare cycles, then done, lt=1. a=b=8'hA5 → 8 compare cycles, eq=1.
- Protocol: start held high and a/b changed during RUN (a=8'h10, b=8'h20 accepted, then a=8'hFF) → result lt=1. Exactly one done pulse; next acceptance only once ready=1.
- Mid-operation reset: a=8'h01, b=8'h01 accepted; rst at 3rd RUN cycle → next edge reset values, no done pulse. A fresh start with a=8'h03, b=8'h02 → gt=1 after 8 compare cycles.
- Random: 1000 random pairs with gaps → result matches a>b / a==b / a<b. Compare-cycle count equals WIDTH minus the index of the first differing bit (WIDTH when equal). One-hot result at every done.

Source files
------------

// File: rtl/serial_cmp_ctrl_pkg.sv
// Shared types for the serial magnitude comparator: FSM states and the internal result code.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } cmp_state_t;

  typedef enum logic [1:0] {
    RES_NONE,
    RES_LT,
    RES_EQ,
    RES_GT
  } cmp_res_t;

endpackage

// File: rtl/serial_cmp_ctrl_if.sv
// Request/result bundle between a requester and the serial comparator controller.
interface serial_cmp_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic             gt;
  logic             eq;
  logic             lt;

  modport master (
    output start, a, b,
    input  ready, busy, done, gt, eq, lt
  );

  modport slave (
    input  start, a, b,
    output ready, busy, done, gt, eq, lt
  );

endinterface

// File: rtl/serial_cmp_ctrl_slice.sv
// One-bit magnitude slice; equality is implied when neither bit_gt nor bit_lt is set.
module cmp_slice_1bit (
  input  logic a_bit,
  input  logic b_bit,
  output logic bit_gt,
  output logic bit_lt
);

  assign bit_gt = a_bit & ~b_bit;
  assign bit_lt = ~a_bit & b_bit;

endmodule

// File: rtl/serial_cmp_ctrl.sv
// MSB-first serial compare: one bit per cycle through a single slice, stopping at the first
// differing bit; 1..WIDTH compare cycles, start ignored outside IDLE.
module serial_cmp_ctrl
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  serial_cmp_ctrl_if.slave bus_if
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

  cmp_state_t       r_state;
  cmp_res_t         r_res;
  logic [IDX_W-1:0] r_idx;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;

  logic w_a_bit;
  logic w_b_bit;
  logic w_bit_gt;
  logic w_bit_lt;

  assign w_a_bit = r_a[r_idx];
  assign w_b_bit = r_b[r_idx];

  cmp_slice_1bit u_slice (
    .a_bit  (w_a_bit),
    .b_bit  (w_b_bit),
    .bit_gt (w_bit_gt),
    .bit_lt (w_bit_lt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_res   <= RES_NONE;
      r_idx   <= IDX_MSB;
      r_a     <= '0;
      r_b     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus_if.start) begin
            r_a     <= bus_if.a;
            r_b     <= bus_if.b;
            r_idx   <= IDX_MSB;
            r_res   <= RES_NONE;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (w_bit_gt) begin
            r_res   <= RES_GT;
            r_state <= DONE;
          end else if (w_bit_lt) begin
            r_res   <= RES_LT;
            r_state <= DONE;
          end else if (r_idx == '0) begin
            // Exit before decrementing so idx never wraps below zero.
            r_res   <= RES_EQ;
            r_state <= DONE;
          end else begin
            r_idx <= r_idx - 1'b1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus_if.ready = (r_state == IDLE);
  assign bus_if.busy  = (r_state == RUN);
  assign bus_if.done  = (r_state == DONE);
  assign bus_if.gt    = (r_res == RES_GT);
  assign bus_if.eq    = (r_res == RES_EQ);
  assign bus_if.lt    = (r_res == RES_LT);

endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// Directed and random checks of serial_cmp_ctrl at WIDTH=8; inputs driven and outputs sampled on negedge.
module tb_serial_cmp_ctrl;

  localparam int WIDTH = 8;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  serial_cmp_ctrl_if #(.WIDTH(WIDTH)) bus();

  serial_cmp_ctrl #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int exp_cycles(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    for (int i = WIDTH - 1; i >= 0; i--)
      if (av[i] != bv[i]) return WIDTH - i;
    return WIDTH;
  endfunction

  function automatic logic [2:0] exp_res(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    if (av > bv)  return 3'b100;
    if (av == bv) return 3'b010;
    return 3'b001;
  endfunction

  // Issue one compare from IDLE and check latency, result and the done pulse.
  task automatic run_cmp(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input string tag);
    int cyc;
    int guard;
    cyc   = 0;
    guard = 0;
    @(negedge clk);
    check({tag, "_ready"}, 32'(bus.ready), 32'd1);
    bus.a     = av;
    bus.b     = bv;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = WIDTH'($urandom);
    bus.b     = WIDTH'($urandom);
    check({tag, "_clr"}, 32'({bus.gt, bus.eq, bus.lt}), 32'd0);
    while (!bus.done && guard < 3 * WIDTH) begin
      if (bus.busy) cyc++;
      guard++;
      @(negedge clk);
    end
    check({tag, "_done"}, 32'(bus.done), 32'd1);
    check({tag, "_cyc"}, 32'(cyc), 32'(exp_cycles(av, bv)));
    check({tag, "_res"}, 32'({bus.gt, bus.eq, bus.lt}), 32'(exp_res(av, bv)));
    check({tag, "_1hot"}, 32'($countones({bus.gt, bus.eq, bus.lt})), 32'd1);
  endtask

  initial begin
    int dn;
    int bz;
    int guard;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    n_chk     = 0;
    n_fail    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_res", 32'({bus.gt, bus.eq, bus.lt}), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_flags", 32'({bus.ready, bus.busy, bus.done}), 32'b100);
    check("idle_res", 32'({bus.gt, bus.eq, bus.lt}), 32'd0);

    run_cmp(8'h80, 8'h7F, "msb_gt");
    @(negedge clk);
    check("msb_gt_pulse", 32'(bus.done), 32'd0);
    @(negedge clk);
    check("msb_gt_hold", 32'({bus.gt, bus.eq, bus.lt}), 32'b100);
    run_cmp(8'h7F, 8'h80, "msb_lt");
    run_cmp(8'h54, 8'h55, "lsb_lt");
    run_cmp(8'hA5, 8'hA5, "equal");

    // start held high with operands changing mid-compare
    @(negedge clk);
    bus.a     = 8'h10;
    bus.b     = 8'h20;
    bus.start = 1'b1;
    @(negedge clk);
    bus.a = 8'hFF;
    check("proto_ready_run", 32'(bus.ready), 32'd0);
    dn    = 0;
    bz    = 0;
    guard = 0;
    while (!bus.done && guard < 3 * WIDTH) begin
      if (bus.busy) bz++;
      guard++;
      @(negedge clk);
    end
    check("proto_done", 32'(bus.done), 32'd1);
    check("proto_cyc", 32'(bz), 32'd3);
    check("proto_res", 32'({bus.gt, bus.eq, bus.lt}), 32'b001);
    @(negedge clk);
    check("proto_ready_after", 32'(bus.ready), 32'd1);
    bus.start = 1'b0;
    bz = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.done) dn++;
      if (bus.busy) bz++;
    end
    check("proto_extra_done", 32'(dn), 32'd0);
    check("proto_extra_busy", 32'(bz), 32'd0);

    // reset in the third RUN cycle aborts the compare without a done
    @(negedge clk);
    bus.a     = 8'h01;
    bus.b     = 8'h01;
    bus.start = 1'b1;
    dn = 0;
    @(negedge clk);
    bus.start = 1'b0;
    if (bus.done) dn++;
    @(negedge clk);
    if (bus.done) dn++;
    @(negedge clk);
    if (bus.done) dn++;
    check("abort_busy_pre", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_flags", 32'({bus.ready, bus.busy, bus.done}), 32'b100);
    check("abort_res", 32'({bus.gt, bus.eq, bus.lt}), 32'd0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
    check("abort_no_done", 32'(dn), 32'd0);
    run_cmp(8'h03, 8'h02, "post_abort");

    for (int k = 0; k < 1000; k++) begin
      ra = WIDTH'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? ra : WIDTH'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_cmp(ra, rb, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
